// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS main control FSM and the ALU
// control decoder. The build macro ILLEGAL_OPCODE_TRAP_EN adds the TRAP state
// and the illegal-opcode flag to the control word.
package mips_ctrl_pkg;

  localparam int OPCODE_W = 6;
  localparam int ALU_OP_W = 3;

  // Instruction opcodes (IR[31:26])
  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OPCODE_W-1:0] OP_LUI   = 6'b001111;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

  // ALU operation classes consumed by the ALU control decoder
  localparam logic [ALU_OP_W-1:0] ALUOP_RTYPE = 3'b111;
  localparam logic [ALU_OP_W-1:0] ALUOP_ADD   = 3'b100;
  localparam logic [ALU_OP_W-1:0] ALUOP_OR    = 3'b101;
  localparam logic [ALU_OP_W-1:0] ALUOP_LUI   = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALUOP_SUB   = 3'b010;

  // ALU operand A source
  localparam logic ALU_A_PC  = 1'b0;
  localparam logic ALU_A_REG = 1'b1;

  // ALU operand B source
  localparam logic [1:0] ALU_B_REG     = 2'b00;
  localparam logic [1:0] ALU_B_FOUR    = 2'b01;
  localparam logic [1:0] ALU_B_IMM     = 2'b10;
  localparam logic [1:0] ALU_B_IMM_SH2 = 2'b11;

  // PC source
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC_R   = 4'd7,
    S_R_WB     = 4'd8,
    S_EXEC_I   = 4'd9,
    S_I_WB     = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12
`ifdef ILLEGAL_OPCODE_TRAP_EN
    , S_TRAP   = 4'd13
`endif
  } state_t;

  // Complete datapath control word produced every cycle
  typedef struct packed {
    logic                pc_write;
    logic                pc_write_cond;
    logic                i_or_d;
    logic                mem_read;
    logic                mem_write;
    logic                ir_write;
    logic                reg_dst;
    logic                mem_to_reg;
    logic                reg_write;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [1:0]          pc_src;
    logic [ALU_OP_W-1:0] alu_op;
    logic                instr_retired;
`ifdef ILLEGAL_OPCODE_TRAP_EN
    logic                illegal_op;
`endif
  } ctrl_t;

  // True for every opcode the FSM knows how to sequence
  function automatic logic is_supported(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_RTYPE, OP_ADDI, OP_ORI, OP_LUI,
      OP_LW, OP_SW, OP_BEQ, OP_J: return 1'b1;
      default:                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control bus between the main control FSM (master) and the datapath (slave).
// Optional macro ILLEGAL_OPCODE_TRAP_EN adds illegal_op_o.
//
// Memory handshake: mem_read_o / mem_write_o act as a request that is held
// high until the memory answers. An access completes in the cycle where the
// request and mem_ready_i are both high; the request may drop on the next
// cycle. mem_ready_i carries no meaning while no request is raised.
interface multicycle_control_unit_if;
  import mips_ctrl_pkg::*;

  logic [OPCODE_W-1:0] opcode_i;
  logic                mem_ready_i;

  logic                pc_write_o;
  logic                pc_write_cond_o;
  logic                i_or_d_o;
  logic                mem_read_o;
  logic                mem_write_o;
  logic                ir_write_o;
  logic                reg_dst_o;
  logic                mem_to_reg_o;
  logic                reg_write_o;
  logic                alu_src_a_o;
  logic [1:0]          alu_src_b_o;
  logic [1:0]          pc_src_o;
  logic [ALU_OP_W-1:0] alu_op_o;
  logic                instr_retired_o;
`ifdef ILLEGAL_OPCODE_TRAP_EN
  logic                illegal_op_o;
`endif
  state_t              dbg_state_o;

  modport master (
    input  opcode_i, mem_ready_i,
    output pc_write_o, pc_write_cond_o, i_or_d_o, mem_read_o, mem_write_o,
           ir_write_o, reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o,
           alu_src_b_o, pc_src_o, alu_op_o, instr_retired_o, dbg_state_o
`ifdef ILLEGAL_OPCODE_TRAP_EN
    , output illegal_op_o
`endif
  );

  modport slave (
    output opcode_i, mem_ready_i,
    input  pc_write_o, pc_write_cond_o, i_or_d_o, mem_read_o, mem_write_o,
           ir_write_o, reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o,
           alu_src_b_o, pc_src_o, alu_op_o, instr_retired_o, dbg_state_o
`ifdef ILLEGAL_OPCODE_TRAP_EN
    , input illegal_op_o
`endif
  );

endinterface

// File: rtl/control_output_decoder.sv
// Pure state -> control-word decode for the multi-cycle MIPS control FSM.
// Optional macro ILLEGAL_OPCODE_TRAP_EN adds the TRAP state decode.
module control_output_decoder
  import mips_ctrl_pkg::*;
(
  input  state_t              i_state,
  input  logic [OPCODE_W-1:0] i_opcode,
  input  logic                i_mem_ready,
  output ctrl_t               o_ctrl
);

  // Moore control word per state; FETCH and MEM_WR qualify the commit with the memory handshake
  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.i_or_d    = 1'b0;
        o_ctrl.alu_src_a = ALU_A_PC;
        o_ctrl.alu_src_b = ALU_B_FOUR;
        o_ctrl.alu_op    = ALUOP_ADD;
        o_ctrl.pc_src    = PC_SRC_ALU;
        // IR and PC+4 only commit once the instruction word has arrived
        o_ctrl.ir_write  = i_mem_ready;
        o_ctrl.pc_write  = i_mem_ready;
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut
        o_ctrl.alu_src_a = ALU_A_PC;
        o_ctrl.alu_src_b = ALU_B_IMM_SH2;
        o_ctrl.alu_op    = ALUOP_ADD;
`ifndef ILLEGAL_OPCODE_TRAP_EN
        // Unknown opcodes complete here as a NOP
        o_ctrl.instr_retired = ~is_supported(i_opcode);
`endif
      end
      S_EXEC_R: begin
        o_ctrl.alu_src_a = ALU_A_REG;
        o_ctrl.alu_src_b = ALU_B_REG;
        o_ctrl.alu_op    = ALUOP_RTYPE;
      end
      S_R_WB: begin
        o_ctrl.reg_dst       = 1'b1;
        o_ctrl.mem_to_reg    = 1'b0;
        o_ctrl.reg_write     = 1'b1;
        o_ctrl.instr_retired = 1'b1;
      end
      S_EXEC_I: begin
        o_ctrl.alu_src_a = ALU_A_REG;
        o_ctrl.alu_src_b = ALU_B_IMM;
        case (i_opcode)
          OP_ORI:  o_ctrl.alu_op = ALUOP_OR;
          OP_LUI:  o_ctrl.alu_op = ALUOP_LUI;
          default: o_ctrl.alu_op = ALUOP_ADD;
        endcase
      end
      S_I_WB: begin
        o_ctrl.reg_dst       = 1'b0;
        o_ctrl.mem_to_reg    = 1'b0;
        o_ctrl.reg_write     = 1'b1;
        o_ctrl.instr_retired = 1'b1;
      end
      S_MEM_ADDR: begin
        o_ctrl.alu_src_a = ALU_A_REG;
        o_ctrl.alu_src_b = ALU_B_IMM;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_RD: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        o_ctrl.reg_dst       = 1'b0;
        o_ctrl.mem_to_reg    = 1'b1;
        o_ctrl.reg_write     = 1'b1;
        o_ctrl.instr_retired = 1'b1;
      end
      S_MEM_WR: begin
        o_ctrl.mem_write     = 1'b1;
        o_ctrl.i_or_d        = 1'b1;
        o_ctrl.instr_retired = i_mem_ready;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a     = ALU_A_REG;
        o_ctrl.alu_src_b     = ALU_B_REG;
        o_ctrl.alu_op        = ALUOP_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_src        = PC_SRC_ALUOUT;
        o_ctrl.instr_retired = 1'b1;
      end
      S_JUMP: begin
        o_ctrl.pc_write      = 1'b1;
        o_ctrl.pc_src        = PC_SRC_JUMP;
        o_ctrl.instr_retired = 1'b1;
      end
`ifdef ILLEGAL_OPCODE_TRAP_EN
      S_TRAP: begin
        o_ctrl.illegal_op = 1'b1;
      end
`endif
      default: begin
        o_ctrl = '0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Main control FSM of the multi-cycle MIPS datapath: state register and
// next-state logic; the control word comes from control_output_decoder.
// Optional macro ILLEGAL_OPCODE_TRAP_EN: unsupported opcodes lock the FSM in
// TRAP (illegal_op_o=1) until reset instead of executing as a NOP.
module multicycle_control_unit
  import mips_ctrl_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  multicycle_control_unit_if.master  bus
);

  state_t r_state;
  state_t w_next_state;
  ctrl_t  w_ctrl;

  // State register with synchronous reset to IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state sequencing from the opcode and the memory handshake
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   w_next_state = S_FETCH;
      S_FETCH:  w_next_state = bus.mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode_i)
          OP_RTYPE:                w_next_state = S_EXEC_R;
          OP_ADDI, OP_ORI, OP_LUI: w_next_state = S_EXEC_I;
          OP_LW, OP_SW:            w_next_state = S_MEM_ADDR;
          OP_BEQ:                  w_next_state = S_BRANCH;
          OP_J:                    w_next_state = S_JUMP;
`ifdef ILLEGAL_OPCODE_TRAP_EN
          default:                 w_next_state = S_TRAP;
`else
          default:                 w_next_state = S_FETCH;
`endif
        endcase
      end
      S_EXEC_R:   w_next_state = S_R_WB;
      S_R_WB:     w_next_state = S_FETCH;
      S_EXEC_I:   w_next_state = S_I_WB;
      S_I_WB:     w_next_state = S_FETCH;
      S_MEM_ADDR: w_next_state = (bus.opcode_i == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   w_next_state = bus.mem_ready_i ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:   w_next_state = S_FETCH;
      S_MEM_WR:   w_next_state = bus.mem_ready_i ? S_FETCH : S_MEM_WR;
      S_BRANCH:   w_next_state = S_FETCH;
      S_JUMP:     w_next_state = S_FETCH;
`ifdef ILLEGAL_OPCODE_TRAP_EN
      S_TRAP:     w_next_state = S_TRAP;
`endif
      default:    w_next_state = S_IDLE;
    endcase
  end

  // Output process: Moore decode of the current state
  control_output_decoder u_decoder (
    .i_state     (r_state),
    .i_opcode    (bus.opcode_i),
    .i_mem_ready (bus.mem_ready_i),
    .o_ctrl      (w_ctrl)
  );

  assign bus.pc_write_o      = w_ctrl.pc_write;
  assign bus.pc_write_cond_o = w_ctrl.pc_write_cond;
  assign bus.i_or_d_o        = w_ctrl.i_or_d;
  assign bus.mem_read_o      = w_ctrl.mem_read;
  assign bus.mem_write_o     = w_ctrl.mem_write;
  assign bus.ir_write_o      = w_ctrl.ir_write;
  assign bus.reg_dst_o       = w_ctrl.reg_dst;
  assign bus.mem_to_reg_o    = w_ctrl.mem_to_reg;
  assign bus.reg_write_o     = w_ctrl.reg_write;
  assign bus.alu_src_a_o     = w_ctrl.alu_src_a;
  assign bus.alu_src_b_o     = w_ctrl.alu_src_b;
  assign bus.pc_src_o        = w_ctrl.pc_src;
  assign bus.alu_op_o        = w_ctrl.alu_op;
  assign bus.instr_retired_o = w_ctrl.instr_retired;
`ifdef ILLEGAL_OPCODE_TRAP_EN
  assign bus.illegal_op_o    = w_ctrl.illegal_op;
`endif
  assign bus.dbg_state_o     = r_state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit. Each instruction is expanded into the
// per-cycle control words it must produce (given its opcode and the number of
// memory wait cycles); those words form the expected queue checked every cycle.
// Honours ILLEGAL_OPCODE_TRAP_EN when the same macro is given to the build.
module tb_multicycle_control_unit;
  import mips_ctrl_pkg::*;

  // Opcodes restated locally so the bench does not share constants with the design
  localparam logic [5:0] L_RTYPE = 6'b000000;
  localparam logic [5:0] L_ADDI  = 6'b001000;
  localparam logic [5:0] L_ORI   = 6'b001101;
  localparam logic [5:0] L_LUI   = 6'b001111;
  localparam logic [5:0] L_LW    = 6'b100011;
  localparam logic [5:0] L_SW    = 6'b101011;
  localparam logic [5:0] L_BEQ   = 6'b000100;
  localparam logic [5:0] L_J     = 6'b000010;

  typedef struct packed {
    logic       pcw, pcwc, iord, mr, mw, irw, rd, m2r, rw, asa;
    logic [1:0] asb;
    logic [1:0] pcs;
    logic [2:0] aop;
    logic       ret;
    logic       ill;
  } exp_t;

  localparam int W = $bits(exp_t) + 1;   // check-enable bit + control word

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_control_unit_if bus ();

  multicycle_control_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  logic [W-1:0] cur_exp;
  string        cur_tag;
  exp_t         act;
  int           n_checks = 0;
  int           n_errors = 0;

  always_comb begin
    act      = '0;
    act.pcw  = bus.pc_write_o;
    act.pcwc = bus.pc_write_cond_o;
    act.iord = bus.i_or_d_o;
    act.mr   = bus.mem_read_o;
    act.mw   = bus.mem_write_o;
    act.irw  = bus.ir_write_o;
    act.rd   = bus.reg_dst_o;
    act.m2r  = bus.mem_to_reg_o;
    act.rw   = bus.reg_write_o;
    act.asa  = bus.alu_src_a_o;
    act.asb  = bus.alu_src_b_o;
    act.pcs  = bus.pc_src_o;
    act.aop  = bus.alu_op_o;
    act.ret  = bus.instr_retired_o;
`ifdef ILLEGAL_OPCODE_TRAP_EN
    act.ill  = bus.illegal_op_o;
`else
    act.ill  = 1'b0;
`endif
  end

  // Compare process: one expected word per cycle, sampled mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur_exp = exp_q.pop_front();
      cur_tag = tag_q.pop_front();
      if (cur_exp[W-1]) begin
        n_checks++;
        if (act !== exp_t'(cur_exp[W-2:0])) begin
          n_errors++;
          $display("FAIL %s: got %b expected %b (state %0d) t=%0t",
                   cur_tag, act, cur_exp[W-2:0], bus.dbg_state_o, $time);
        end
        if (act.mr === 1'b1 && act.mw === 1'b1) begin
          n_errors++;
          $display("FAIL rd_wr_exclusive: got mem_read=1 mem_write=1 required not both t=%0t", $time);
        end
      end
    end
  end

  // ---------------- expected control words ----------------
  function automatic exp_t w_zero();
    exp_t e; e = '0; return e;
  endfunction
  function automatic exp_t w_fetch(input logic rdy);
    exp_t e; e = '0; e.mr = 1'b1; e.asb = 2'b01; e.aop = 3'b100;
    e.irw = rdy; e.pcw = rdy; return e;
  endfunction
  function automatic exp_t w_decode(input logic ret);
    exp_t e; e = '0; e.asb = 2'b11; e.aop = 3'b100; e.ret = ret; return e;
  endfunction
  function automatic exp_t w_exec_r();
    exp_t e; e = '0; e.asa = 1'b1; e.asb = 2'b00; e.aop = 3'b111; return e;
  endfunction
  function automatic exp_t w_exec_i(input logic [2:0] aop);
    exp_t e; e = '0; e.asa = 1'b1; e.asb = 2'b10; e.aop = aop; return e;
  endfunction
  function automatic exp_t w_mem_rd();
    exp_t e; e = '0; e.mr = 1'b1; e.iord = 1'b1; return e;
  endfunction
  function automatic exp_t w_mem_wr(input logic rdy);
    exp_t e; e = '0; e.mw = 1'b1; e.iord = 1'b1; e.ret = rdy; return e;
  endfunction
  function automatic exp_t w_wb(input logic rd, input logic m2r);
    exp_t e; e = '0; e.rd = rd; e.m2r = m2r; e.rw = 1'b1; e.ret = 1'b1; return e;
  endfunction
  function automatic exp_t w_branch();
    exp_t e; e = '0; e.asa = 1'b1; e.aop = 3'b010; e.pcwc = 1'b1;
    e.pcs = 2'b01; e.ret = 1'b1; return e;
  endfunction
  function automatic exp_t w_jump();
    exp_t e; e = '0; e.pcw = 1'b1; e.pcs = 2'b10; e.ret = 1'b1; return e;
  endfunction
  function automatic exp_t w_trap();
    exp_t e; e = '0; e.ill = 1'b1; return e;
  endfunction

  function automatic logic [5:0] rop();
    return 6'($urandom_range(0, 63));
  endfunction
  function automatic logic rr();
    return 1'($urandom_range(0, 1));
  endfunction
  function automatic logic known_op(input logic [5:0] op);
    return (op == L_RTYPE) || (op == L_ADDI) || (op == L_ORI) || (op == L_LUI) ||
           (op == L_LW) || (op == L_SW) || (op == L_BEQ) || (op == L_J);
  endfunction

  // ---------------- driver tasks ----------------
  // One clock cycle: apply inputs, queue what the outputs must be during it
  task automatic cyc(input logic rst, input logic rdy, input logic [5:0] op,
                     input logic chk, input exp_t e, input string tag);
    reset           = rst;
    bus.mem_ready_i = rdy;
    bus.opcode_i    = op;
    exp_q.push_back({chk, e});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  // Whole instruction starting in FETCH: fw fetch waits, mw data-memory waits
  task automatic do_instr(input logic [5:0] op, input int fw, input int mw, output int ncyc);
    ncyc = 0;
    for (int i = 0; i < fw; i++) begin
      cyc(1'b0, 1'b0, rop(), 1'b1, w_fetch(1'b0), "fetch_wait"); ncyc++;
    end
    cyc(1'b0, 1'b1, rop(), 1'b1, w_fetch(1'b1), "fetch_ready"); ncyc++;
    if (known_op(op)) begin
      cyc(1'b0, rr(), op, 1'b1, w_decode(1'b0), "decode"); ncyc++;
    end
    case (op)
      L_RTYPE: begin
        cyc(1'b0, rr(), op, 1'b1, w_exec_r(), "exec_r");
        cyc(1'b0, rr(), op, 1'b1, w_wb(1'b1, 1'b0), "r_wb");
        ncyc += 2;
      end
      L_ADDI, L_ORI, L_LUI: begin
        cyc(1'b0, rr(), op, 1'b1,
            w_exec_i(op == L_ADDI ? 3'b100 : (op == L_ORI ? 3'b101 : 3'b000)), "exec_i");
        cyc(1'b0, rr(), op, 1'b1, w_wb(1'b0, 1'b0), "i_wb");
        ncyc += 2;
      end
      L_LW: begin
        cyc(1'b0, rr(), op, 1'b1, w_exec_i(3'b100), "mem_addr_lw"); ncyc++;
        for (int i = 0; i < mw; i++) begin
          cyc(1'b0, 1'b0, op, 1'b1, w_mem_rd(), "mem_rd_wait"); ncyc++;
        end
        cyc(1'b0, 1'b1, op, 1'b1, w_mem_rd(), "mem_rd_ready");
        cyc(1'b0, rr(), op, 1'b1, w_wb(1'b0, 1'b1), "mem_wb");
        ncyc += 2;
      end
      L_SW: begin
        cyc(1'b0, rr(), op, 1'b1, w_exec_i(3'b100), "mem_addr_sw"); ncyc++;
        for (int i = 0; i < mw; i++) begin
          cyc(1'b0, 1'b0, op, 1'b1, w_mem_wr(1'b0), "mem_wr_wait"); ncyc++;
        end
        cyc(1'b0, 1'b1, op, 1'b1, w_mem_wr(1'b1), "mem_wr_ready"); ncyc++;
      end
      L_BEQ: begin
        cyc(1'b0, rr(), op, 1'b1, w_branch(), "branch"); ncyc++;
      end
      L_J: begin
        cyc(1'b0, rr(), op, 1'b1, w_jump(), "jump"); ncyc++;
      end
      default: begin
`ifdef ILLEGAL_OPCODE_TRAP_EN
        cyc(1'b0, rr(), op, 1'b1, w_decode(1'b0), "decode_illegal");
        for (int i = 0; i < 3; i++) cyc(1'b0, rr(), rop(), 1'b1, w_trap(), "trap_hold");
        cyc(1'b1, rr(), rop(), 1'b1, w_trap(), "trap_reset_edge");
        cyc(1'b0, rr(), rop(), 1'b1, w_zero(), "idle_after_trap");
        ncyc += 6;
`else
        cyc(1'b0, rr(), op, 1'b1, w_decode(1'b1), "decode_nop"); ncyc++;
`endif
      end
    endcase
  endtask

  task automatic pin_len(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL len_%s: got %0d cycles required %0d", name, got, want);
    end
  endtask

  // ---------------- stimulus ----------------
  int n;
  int k;
  logic [5:0] op;

  initial begin
    reset           = 1'b1;
    bus.mem_ready_i = 1'b0;
    bus.opcode_i    = 6'd0;
    @(posedge clk);
    #1;
    cyc(1'b1, rr(), rop(), 1'b0, w_zero(), "reset_startup");
    cyc(1'b1, rr(), rop(), 1'b1, w_zero(), "reset_held");
    cyc(1'b0, rr(), rop(), 1'b1, w_zero(), "idle");

    // Directed instructions with cycle-count pins
    do_instr(L_RTYPE, 0, 0, n); pin_len("rtype", n, 4);
    do_instr(L_LW,    0, 2, n); pin_len("lw_2wait", n, 7);
    do_instr(L_SW,    1, 0, n); pin_len("sw_fetchwait", n, 5);
    do_instr(L_BEQ,   0, 0, n); pin_len("beq", n, 3);
    do_instr(L_J,     0, 0, n); pin_len("j", n, 3);
    do_instr(L_ADDI,  0, 0, n); pin_len("addi", n, 4);
    do_instr(L_ORI,   0, 0, n);
    do_instr(L_LUI,   0, 0, n);
    do_instr(6'b111111, 0, 0, n);
`ifdef ILLEGAL_OPCODE_TRAP_EN
    pin_len("illegal_trap", n, 7);
`else
    pin_len("illegal_nop", n, 2);
`endif

    // Reset held 3 cycles in the middle of a load's data read
    cyc(1'b0, 1'b1, rop(), 1'b1, w_fetch(1'b1), "fetch_ready");
    cyc(1'b0, rr(), L_LW, 1'b1, w_decode(1'b0), "decode");
    cyc(1'b0, rr(), L_LW, 1'b1, w_exec_i(3'b100), "mem_addr_lw");
    cyc(1'b0, 1'b0, L_LW, 1'b1, w_mem_rd(), "mem_rd_wait");
    cyc(1'b1, 1'b0, L_LW, 1'b1, w_mem_rd(), "mem_rd_reset_edge");
    cyc(1'b1, rr(), rop(), 1'b1, w_zero(), "reset_held");
    cyc(1'b1, rr(), rop(), 1'b1, w_zero(), "reset_held");
    cyc(1'b0, rr(), rop(), 1'b1, w_zero(), "idle_after_reset");
    do_instr(L_RTYPE, 0, 0, n);

    // Randomised instruction stream
    for (int i = 0; i < 250; i++) begin
      k = $urandom_range(0, 8);
      case (k)
        0: op = L_RTYPE;
        1: op = L_ADDI;
        2: op = L_ORI;
        3: op = L_LUI;
        4: op = L_LW;
        5: op = L_SW;
        6: op = L_BEQ;
        7: op = L_J;
        default: begin
          op = rop();
          while (known_op(op)) op = rop();
        end
      endcase
      do_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), n);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
